// File: rtl/free_list_ctrl_pkg.sv
// Shared types for the rename-stage free-list controller.
package free_list_ctrl_pkg;

    localparam int unsigned TagWidth = 7;

    typedef logic [TagWidth-1:0] tag_t;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } fl_state_e;

endpackage

// File: rtl/free_list_ptr_add.sv
// Modular pointer add for a circular list whose depth need not be a power of two.
module free_list_ptr_add #(
    parameter int unsigned DEPTH = 94,
    parameter int unsigned INDEX = 7
) (
    input  logic [INDEX-1:0] base_i,
    input  logic [INDEX:0]   incr_i,
    output logic [INDEX-1:0] sum_o,
    output logic             wrap_o
);

    logic [INDEX+1:0] raw;
    logic [INDEX+1:0] wrapped;

    // Operands are bounded by DEPTH, so a single subtract brings the sum back in range.
    assign raw     = {2'b00, base_i} + {1'b0, incr_i};
    assign wrap_o  = raw >= (INDEX+2)'(DEPTH);
    assign wrapped = raw - (INDEX+2)'(DEPTH);
    assign sum_o   = wrap_o ? wrapped[INDEX-1:0] : raw[INDEX-1:0];

endmodule

// File: rtl/free_list_ctrl.sv
// Speculative free-list controller: head/tail pointers, free count and RAM power-up init.
module free_list_ctrl
    import free_list_ctrl_pkg::*;
#(
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned COMMIT_WIDTH   = 4,
    parameter int unsigned DEPTH          = 94,
    parameter int unsigned INDEX          = 7,
    parameter int unsigned WIDTH          = TagWidth,
    parameter int unsigned BASE_TAG       = 34
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              recover_i,
    input  logic [DISPATCH_WIDTH-1:0]         alloc_req_i,
    output logic                              alloc_stall_o,
    output logic [DISPATCH_WIDTH*WIDTH-1:0]   alloc_tag_o,
    input  logic [COMMIT_WIDTH-1:0]           rel_valid_i,
    input  logic [COMMIT_WIDTH*WIDTH-1:0]     rel_tag_i,
    output logic [INDEX:0]                    free_count_o,
    output logic                              init_busy_o,
    output logic [DISPATCH_WIDTH*INDEX-1:0]   ram_raddr_o,
    input  logic [DISPATCH_WIDTH*WIDTH-1:0]   ram_rdata_i,
    output logic [COMMIT_WIDTH*INDEX-1:0]     ram_waddr_o,
    output logic [COMMIT_WIDTH*WIDTH-1:0]     ram_wdata_o,
    output logic [COMMIT_WIDTH-1:0]           ram_we_o
);

    fl_state_e        state_q, state_d;
    logic [INDEX-1:0] head_q, head_d;
    logic [INDEX-1:0] tail_q, tail_d;
    logic [INDEX-1:0] init_ptr_q, init_ptr_d;
    logic [INDEX:0]   count_q, count_d;

    logic [INDEX:0]   alloc_n;
    logic [INDEX:0]   rel_n;
    logic [INDEX:0]   rel_pos [COMMIT_WIDTH];
    logic [INDEX:0]   granted;
    logic             grant;

    logic [INDEX-1:0] head_lane [DISPATCH_WIDTH];
    logic [INDEX-1:0] tail_lane [COMMIT_WIDTH];
    logic [INDEX-1:0] init_lane [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] init_wrap;
    logic [INDEX-1:0] head_next, tail_next, init_next;
    logic             init_last;

    logic [INDEX-1:0] waddr [COMMIT_WIDTH];
    logic [WIDTH-1:0] wdata [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] we;

    // Population counts; rel_pos[j] is the compacted slot of release lane j.
    always_comb begin
        alloc_n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            alloc_n = alloc_n + (INDEX+1)'(alloc_req_i[i]);
        end
        rel_n = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            rel_pos[j] = rel_n;
            rel_n      = rel_n + (INDEX+1)'(rel_valid_i[j]);
        end
    end

    logic [DISPATCH_WIDTH-1:0] unused_head_wrap;
    logic [COMMIT_WIDTH-1:0]   unused_tail_wrap;
    logic                      unused_next_wrap;
    logic                      unused_tail_next_wrap;

    for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_head
        free_list_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_add (
            .base_i (head_q),
            .incr_i ((INDEX+1)'(i)),
            .sum_o  (head_lane[i]),
            .wrap_o (unused_head_wrap[i])
        );
        assign ram_raddr_o[i*INDEX +: INDEX] = head_lane[i];
    end

    free_list_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_head_next (
        .base_i (head_q),
        .incr_i (alloc_n),
        .sum_o  (head_next),
        .wrap_o (unused_next_wrap)
    );

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_tail
        free_list_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_add (
            .base_i (tail_q),
            .incr_i ((INDEX+1)'(k)),
            .sum_o  (tail_lane[k]),
            .wrap_o (unused_tail_wrap[k])
        );
    end

    free_list_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_tail_next (
        .base_i (tail_q),
        .incr_i (rel_n),
        .sum_o  (tail_next),
        .wrap_o (unused_tail_next_wrap)
    );

    // A wrapping init lane points past the last entry and stays idle.
    for (genvar j = 0; j < COMMIT_WIDTH; j++) begin : g_init
        free_list_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_add (
            .base_i (init_ptr_q),
            .incr_i ((INDEX+1)'(j)),
            .sum_o  (init_lane[j]),
            .wrap_o (init_wrap[j])
        );
    end

    free_list_ptr_add #(.DEPTH(DEPTH), .INDEX(INDEX)) u_init_next (
        .base_i (init_ptr_q),
        .incr_i ((INDEX+1)'(COMMIT_WIDTH)),
        .sum_o  (init_next),
        .wrap_o (init_last)
    );

    assign alloc_tag_o   = ram_rdata_i;
    assign alloc_stall_o = (state_q != StRun) || recover_i || (alloc_n > count_q);
    assign grant         = !alloc_stall_o;
    assign granted       = grant ? alloc_n : '0;
    assign free_count_o  = count_q;
    assign init_busy_o   = (state_q == StInit);

    always_comb begin
        we = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            waddr[k] = '0;
            wdata[k] = '0;
        end
        if (!reset) begin
            unique case (state_q)
                StInit: begin
                    for (int j = 0; j < COMMIT_WIDTH; j++) begin
                        if (!init_wrap[j]) begin
                            we[j]    = 1'b1;
                            waddr[j] = init_lane[j];
                            wdata[j] = WIDTH'(BASE_TAG) + WIDTH'(init_lane[j]);
                        end
                    end
                end
                StRun: begin
                    for (int k = 0; k < COMMIT_WIDTH; k++) begin
                        for (int j = 0; j < COMMIT_WIDTH; j++) begin
                            if (rel_valid_i[j] && rel_pos[j] == (INDEX+1)'(k)) begin
                                we[k]    = 1'b1;
                                waddr[k] = tail_lane[k];
                                wdata[k] = rel_tag_i[j*WIDTH +: WIDTH];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_wport
        assign ram_waddr_o[k*INDEX +: INDEX] = waddr[k];
        assign ram_wdata_o[k*WIDTH +: WIDTH] = wdata[k];
    end
    assign ram_we_o = we;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        init_ptr_d = init_ptr_q;
        count_d    = count_q;
        unique case (state_q)
            StInit: begin
                init_ptr_d = init_next;
                if (init_last) begin
                    state_d    = StRun;
                    init_ptr_d = '0;
                    head_d     = '0;
                    tail_d     = '0;
                    count_d    = (INDEX+1)'(DEPTH);
                end
            end
            StRun: begin
                tail_d = tail_next;
                if (recover_i) begin
                    // Squashed tags become free again; releases this cycle still land.
                    head_d  = tail_next;
                    count_d = (INDEX+1)'(DEPTH);
                end else begin
                    if (grant) head_d = head_next;
                    count_d = count_q + rel_n - granted;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            head_q     <= '0;
            tail_q     <= '0;
            init_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            init_ptr_q <= init_ptr_d;
            count_q    <= count_d;
        end
    end

    logic [INDEX+1:0] count_sum;
    assign count_sum = {1'b0, count_q} + {1'b0, rel_n} - {1'b0, granted};

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (state_q == StRun && !recover_i) |-> count_sum <= (INDEX+2)'(DEPTH));

endmodule

// File: tb/tb_free_list_ctrl.sv
// Randomized bench for free_list_ctrl against a queue/array reference model.
module tb_free_list_ctrl;

    localparam int D    = 94;
    localparam int BASE = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        recover_i;
    logic [3:0]  alloc_req_i;
    logic        alloc_stall_o;
    logic [27:0] alloc_tag_o;
    logic [3:0]  rel_valid_i;
    logic [27:0] rel_tag_i;
    logic [7:0]  free_count_o;
    logic        init_busy_o;
    logic [27:0] ram_raddr_o;
    logic [27:0] ram_rdata_i;
    logic [27:0] ram_waddr_o;
    logic [27:0] ram_wdata_o;
    logic [3:0]  ram_we_o;

    free_list_ctrl #(
        .DISPATCH_WIDTH(4), .COMMIT_WIDTH(4), .DEPTH(94), .INDEX(7), .WIDTH(7), .BASE_TAG(34)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .recover_i     (recover_i),
        .alloc_req_i   (alloc_req_i),
        .alloc_stall_o (alloc_stall_o),
        .alloc_tag_o   (alloc_tag_o),
        .rel_valid_i   (rel_valid_i),
        .rel_tag_i     (rel_tag_i),
        .free_count_o  (free_count_o),
        .init_busy_o   (init_busy_o),
        .ram_raddr_o   (ram_raddr_o),
        .ram_rdata_i   (ram_rdata_i),
        .ram_waddr_o   (ram_waddr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_we_o      (ram_we_o)
    );

    always #5 clk = ~clk;

    // Free-list RAM: combinational read, clocked write, no reset.
    logic [6:0] ram [D];
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ram_rdata_i[i*7 +: 7] = (ram_raddr_o[i*7 +: 7] < 7'(D)) ? ram[ram_raddr_o[i*7 +: 7]] : 7'd0;
        end
    end
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (ram_we_o[j] && ram_waddr_o[j*7 +: 7] < 7'(D)) ram[ram_waddr_o[j*7 +: 7]] <= ram_wdata_o[j*7 +: 7];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list contents as a plain array, pointers as integers mod D.
    logic [6:0] ref_mem [D];
    logic [6:0] out_q [$];
    int m_run, m_iptr, m_head, m_tail, m_cnt;

    always @(negedge clk) begin
        int n, m, k, granted, ram_bad;
        logic stall_exp;
        logic [6:0] tag;
        int idx [$];
        ram_bad = 0;
        for (int i = 0; i < D; i++) if (ram[i] !== ref_mem[i]) ram_bad++;
        check("ram_contents", ram_bad, 0);
        if (reset) begin
            check("rst_busy", init_busy_o, 1);
            check("rst_stall", alloc_stall_o, 1);
            check("rst_count", free_count_o, 0);
            check("rst_we", ram_we_o, 0);
            m_run = 0; m_iptr = 0; m_head = 0; m_tail = 0; m_cnt = 0;
            out_q.delete();
        end else if (m_run == 0) begin
            check("init_busy", init_busy_o, 1);
            check("init_stall", alloc_stall_o, 1);
            check("init_count", free_count_o, 0);
            for (int j = 0; j < 4; j++) begin
                check("init_we", ram_we_o[j], (m_iptr + j < D) ? 1 : 0);
                if (m_iptr + j < D) begin
                    check("init_waddr", ram_waddr_o[j*7 +: 7], m_iptr + j);
                    check("init_wdata", ram_wdata_o[j*7 +: 7], BASE + m_iptr + j);
                    ref_mem[m_iptr + j] = 7'(BASE + m_iptr + j);
                end
            end
            m_iptr += 4;
            if (m_iptr >= D) begin
                m_run = 1; m_cnt = D; m_head = 0; m_tail = 0;
            end
        end else begin
            check("run_busy", init_busy_o, 0);
            check("run_count", free_count_o, m_cnt);
            n = $countones(alloc_req_i);
            stall_exp = recover_i || (n > m_cnt);
            check("run_stall", alloc_stall_o, stall_exp);
            for (int i = 0; i < 4; i++) check("run_raddr", ram_raddr_o[i*7 +: 7], (m_head + i) % D);
            granted = stall_exp ? 0 : n;
            for (int i = 0; i < granted; i++) begin
                check("run_tag", alloc_tag_o[i*7 +: 7], ref_mem[(m_head + i) % D]);
                out_q.push_back(ref_mem[(m_head + i) % D]);
            end
            m = $countones(rel_valid_i);
            check("run_we_count", $countones(ram_we_o), m);
            k = 0;
            for (int j = 0; j < 4; j++) begin
                if (rel_valid_i[j]) begin
                    tag = rel_tag_i[j*7 +: 7];
                    ref_mem[(m_tail + k) % D] = tag;
                    idx = out_q.find_first_index(x) with (x == tag);
                    if (idx.size() > 0) out_q.delete(idx[0]);
                    k++;
                end
            end
            m_tail = (m_tail + m) % D;
            if (recover_i) begin
                m_head = m_tail; m_cnt = D;
                out_q.delete();
            end else begin
                m_head = (m_head + granted) % D;
                m_cnt  = m_cnt + m - granted;
            end
        end
    end

    // One cycle: drive after the rising edge, return just after the falling edge.
    task automatic cyc(input logic [3:0] req, input logic [3:0] rv, input logic [27:0] tags,
                       input logic rec);
        @(posedge clk);
        #1;
        alloc_req_i = req;
        rel_valid_i = rv;
        rel_tag_i   = tags;
        recover_i   = rec;
        @(negedge clk);
        #1;
    endtask

    task automatic pick(input logic [3:0] mask, output logic [27:0] tags);
        int k;
        k = 0;
        tags = '0;
        for (int j = 0; j < 4; j++) begin
            if (mask[j]) begin
                tags[j*7 +: 7] = out_q[k];
                k++;
            end
        end
    endtask

    task automatic wait_init();
        int c;
        c = 0;
        for (int b = 0; b < 200; b++) begin
            @(negedge clk);
            #1;
            if (!init_busy_o) break;
            c++;
        end
        check("init_cycles", c, 24);
        check("post_init_count", free_count_o, 94);
    endtask

    initial begin
        logic [27:0] tags;
        logic [3:0]  mask;
        logic [6:0]  t0, t1, t2;
        int n;
        reset = 1'b1; recover_i = 0; alloc_req_i = 0; rel_valid_i = 0; rel_tag_i = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_init();
        check("ram0", ram[0], 34);
        check("ram93", ram[93], 127);

        // Drain the list to two entries.
        for (int c = 0; c < 23; c++) begin
            cyc(4'hf, 4'h0, '0, 1'b0);
            if (c == 0) begin
                check("first_tag0", alloc_tag_o[6:0], 34);
                check("first_tag3", alloc_tag_o[27:21], 37);
            end
        end
        for (int c = 0; c < 2; c++) begin
            cyc(4'hf, 4'h0, '0, 1'b0);
            check("stall_lit", alloc_stall_o, 1);
            check("stall_count", free_count_o, 2);
            check("stall_head", ram_raddr_o[6:0], 92);
        end
        tags = '0;
        tags[13:7]  = 7'd40;
        tags[27:21] = 7'd50;
        cyc(4'b0011, 4'b1010, tags, 1'b0);
        check("grant_stall", alloc_stall_o, 0);
        check("grant_tag0", alloc_tag_o[6:0], 126);
        check("grant_tag1", alloc_tag_o[13:7], 127);
        cyc(4'h0, 4'h0, '0, 1'b0);
        check("rel_ram0", ram[0], 40);
        check("rel_ram1", ram[1], 50);
        check("rel_count", free_count_o, 2);

        // Move both pointers to 92, then wrap.
        for (int c = 0; c < 22; c++) begin
            pick(4'hf, tags);
            cyc(4'h0, 4'hf, tags, 1'b0);
        end
        pick(4'b0011, tags);
        cyc(4'h0, 4'b0011, tags, 1'b0);
        for (int c = 0; c < 23; c++) cyc(4'hf, 4'h0, '0, 1'b0);
        pick(4'hf, tags);
        cyc(4'h0, 4'hf, tags, 1'b0);
        cyc(4'b0111, 4'h0, '0, 1'b0);
        check("wrap_stall", alloc_stall_o, 0);
        check("wrap_raddr0", ram_raddr_o[6:0], 92);
        check("wrap_raddr1", ram_raddr_o[13:7], 93);
        check("wrap_raddr2", ram_raddr_o[20:14], 0);
        cyc(4'h0, 4'h0, '0, 1'b0);
        check("wrap_head", ram_raddr_o[6:0], 1);
        check("wrap_count", free_count_o, 1);

        // Recover at tail=10 with three releases.
        for (int c = 0; c < 2; c++) begin
            pick(4'hf, tags);
            cyc(4'h0, 4'hf, tags, 1'b0);
        end
        pick(4'b0111, tags);
        t0 = tags[6:0]; t1 = tags[13:7]; t2 = tags[20:14];
        cyc(4'h0, 4'b0111, tags, 1'b1);
        check("rec_stall", alloc_stall_o, 1);
        cyc(4'hf, 4'h0, '0, 1'b0);
        check("rec_count", free_count_o, 94);
        check("rec_head", ram_raddr_o[6:0], 13);
        check("rec_ram10", ram[10], t0);
        check("rec_ram11", ram[11], t1);
        check("rec_ram12", ram[12], t2);
        for (int i = 0; i < 4; i++) check("rec_tag", alloc_tag_o[i*7 +: 7], ram[13 + i]);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            n = $urandom_range(0, 4);
            mask = 4'($urandom_range(0, 15));
            while ($countones(mask) > out_q.size()) mask = mask & (mask - 4'd1);
            pick(mask, tags);
            cyc(4'((1 << n) - 1), mask, tags, ($urandom_range(0, 39) == 0));
        end

        // Reset mid-RUN at count 50.
        cyc(4'h0, 4'h0, '0, 1'b1);
        for (int c = 0; c < 11; c++) cyc(4'hf, 4'h0, '0, 1'b0);
        cyc(4'h0, 4'h0, '0, 1'b0);
        check("pre_reset_count", free_count_o, 50);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_busy", init_busy_o, 1);
        check("async_stall", alloc_stall_o, 1);
        check("async_count", free_count_o, 0);
        check("async_we", ram_we_o, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_init();
        for (int c = 0; c < 200; c++) begin
            n = $urandom_range(0, 4);
            mask = 4'($urandom_range(0, 15));
            while ($countones(mask) > out_q.size()) mask = mask & (mask - 4'd1);
            pick(mask, tags);
            cyc(4'((1 << n) - 1), mask, tags, ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/free_list_ctrl.md
# free_list_ctrl

Speculative free-list controller for the rename stage. It owns the head and tail pointers, the free count and the power-up initialisation sequence of the free-list RAM. Each cycle it hands up to DISPATCH_WIDTH free physical tags to rename and writes up to COMMIT_WIDTH released tags from retire back into the RAM. It sits between rename/dispatch, retire and the free-list RAM macro; the RAM has no reset and is driven only through this block.

## Interface
- DISPATCH_WIDTH, 4: allocation lanes (RAM read ports)
- COMMIT_WIDTH, 4: release lanes (RAM write ports)
- DEPTH, 94: free-list entries (physical regs minus RMT size); any value ≥ DISPATCH_WIDTH and ≥ COMMIT_WIDTH
- INDEX, 7: pointer width, ceil(log2(DEPTH))
- WIDTH, 7: physical tag width
- BASE_TAG, 34: first tag loaded at init (RMT size)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- recover_i  in  1  pipeline flush; restore the full free list
- alloc_req_i  in  DISPATCH_WIDTH  per-lane request; set lanes are contiguous from lane 0
- alloc_stall_o  out  1  request not grantable this cycle
- alloc_tag_o  out  DISPATCH_WIDTH*WIDTH  lane i tag, valid when alloc_req_i[i] and !alloc_stall_o
- rel_valid_i  in  COMMIT_WIDTH  per-lane release valid; any pattern is legal
- rel_tag_i  in  COMMIT_WIDTH*WIDTH  released tags
- free_count_o  out  INDEX+1  registered free count
- init_busy_o  out  1  initialisation in progress
- ram_raddr_o  out  DISPATCH_WIDTH*INDEX  RAM read addresses
- ram_rdata_i  in  DISPATCH_WIDTH*WIDTH  combinational RAM read data
- ram_waddr_o / ram_wdata_o / ram_we_o  out  COMMIT_WIDTH*INDEX / COMMIT_WIDTH*WIDTH / COMMIT_WIDTH  RAM write ports

## Operation
- The FSM has two states: INIT and RUN. Reset forces INIT with head=tail=init_ptr=0 and count=0. Reset outputs: init_busy_o=1, alloc_stall_o=1, free_count_o=0, ram_we_o=0.
- **INIT:**
  - Each cycle, write lanes j < COMMIT_WIDTH with init_ptr+j < DEPTH get waddr=init_ptr+j, wdata=BASE_TAG+init_ptr+j, we=1.
  - init_ptr advances by COMMIT_WIDTH.
  - When the last entry is written, the next state is RUN with count=DEPTH, head=tail=0.
  - alloc_req_i, rel_valid_i and recover_i are ignored in INIT.
- **RUN, allocation:**
  - n = popcount(alloc_req_i).
  - ram_raddr_o lane i = (head+i) mod DEPTH, always driven; alloc_tag_o lane i = ram_rdata_i lane i.
  - alloc_stall_o = (n > count), using the registered count only. Same-cycle releases do not help.
  - On grant (no stall, no recover), head += n mod DEPTH.
- **RUN, release:**
  - Valid lanes are compacted in lane order: the k-th valid lane writes at (tail+k) mod DEPTH.
  - Unused write lanes have we=0.
  - tail += popcount(rel_valid_i).
- **Count update:** count_next = count + released − granted. Overflow above DEPTH is a protocol error and is flagged by an assertion.
- **Recover:**
  - Allocation is suppressed and alloc_stall_o=1 in that cycle.
  - Same-cycle releases are still written, and tail advances.
  - head_next = tail_next and count_next = DEPTH. Slots in [tail, head) still hold the squashed tags.
- Pointer wrap uses subtract-on-overflow, so DEPTH need not be a power of two.

## Timing
- Tag read is zero-latency: alloc_tag_o is valid in the request cycle (combinational through the RAM).
- Pointers, count and FSM update on the rising clk edge; free_count_o reflects them the next cycle.
- A release written in cycle t is readable by allocation in cycle t+1 at the earliest.
- Init takes ceil(DEPTH/COMMIT_WIDTH) cycles; RUN starts the following cycle.
- Reset asserted mid-operation returns to INIT asynchronously, and the RAM is re-initialised.
- Stall is all-or-nothing: no partial grants.

## Structure
- A shared package holds the FSM state enum and a tag typedef sized by WIDTH.
- Sub-module free_list_ptr_add performs the modular pointer add, one instance per lane. It is reused for the head, tail and init pointers.
- The RAM is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle with defaults: init_busy_o high for 24 cycles. The RAM holds tags 34..127 at entries 0..93. free_count_o=94 after init.
- Alloc 4 lanes per cycle for 23 cycles (tags 34..125), then 4 lanes with count=2: alloc_stall_o=1, head is unchanged and count stays 2.
- With count=2, simultaneous 2-lane alloc and release of tags {40,50} on lanes 1 and 3: grant tags 126,127. The RAM is written at tail, tail+1 = 0,1. count stays 2.
- Head and tail wrap: pointers at 92, 3-lane alloc reads addresses 92, 93, 0. head_next=1.
- Recover with 3 same-cycle releases at tail=10: writes at 10..12, then head=tail=13 and count=94. The next alloc returns RAM[13..16].
- Reset asserted mid-RUN with count=50: immediate INIT, outputs at reset values, and full re-initialisation to count=94.
